// File: rtl/multsum_sched_pkg.sv
// Shared types and constants for the multsum scheduler and its arithmetic core.
package multsum_sched_pkg;

  localparam int W_DEF  = 32;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Ceiling log2, floored at 1 so a grant index always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multsum_core.sv
// Sum-of-multiples engine: sums k in [0,limit) where k is a multiple of div_a or div_b.
// Uses wrapping residue counters instead of a divider; one k per cycle.
module multsum_core
  import multsum_sched_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  limit,
  input  logic [DW-1:0] div_a,
  input  logic [DW-1:0] div_b,
  output logic          done,
  output logic [W-1:0]  sum
);

  logic          run_r;
  logic          done_r;
  logic [W-1:0]  k_r;
  logic [W-1:0]  lim_r;
  logic [W-1:0]  sum_r;
  logic [DW-1:0] da_r;
  logic [DW-1:0] db_r;
  logic [DW-1:0] ra_r;
  logic [DW-1:0] rb_r;
  logic          hit_s;

  assign hit_s = (ra_r == '0) || (rb_r == '0);
  assign done  = done_r;
  assign sum   = sum_r;

  // Iteration engine: start (re)loads the job, then one k per cycle until limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r  <= 1'b0;
      done_r <= 1'b0;
      k_r    <= '0;
      lim_r  <= '0;
      sum_r  <= '0;
      da_r   <= '0;
      db_r   <= '0;
      ra_r   <= '0;
      rb_r   <= '0;
    end else if (start) begin
      lim_r  <= limit;
      da_r   <= div_a;
      db_r   <= div_b;
      k_r    <= '0;
      ra_r   <= '0;
      rb_r   <= '0;
      sum_r  <= '0;
      // An empty range finishes on the very next cycle.
      run_r  <= (limit != '0);
      done_r <= (limit == '0);
    end else if (run_r) begin
      sum_r <= sum_r + (hit_s ? k_r : '0);
      k_r   <= k_r + W'(1);
      ra_r  <= (ra_r == da_r - DW'(1)) ? '0 : ra_r + DW'(1);
      rb_r  <= (rb_r == db_r - DW'(1)) ? '0 : rb_r + DW'(1);
      if (k_r == lim_r - W'(1)) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: rtl/multsum_sched.sv
// Round-robin scheduler sharing one multsum_core among NREQ requesters.
module multsum_sched
  import multsum_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF,
  parameter int DW   = DW_DEF,
  localparam int IW  = clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*W-1:0]  req_limit,
  input  logic [NREQ*DW-1:0] req_div_a,
  input  logic [NREQ*DW-1:0] req_div_b,
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [W-1:0]     rsp_sum,
  output logic             rsp_err,
  output logic             busy,
  output logic [IW-1:0]    grant_id
);

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t        state_r;
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] grant_id_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [W-1:0]  rsp_sum_r;
  logic          rsp_err_r;
  logic          busy_r;
  logic          core_start_r;
  logic [W-1:0]  lim_r;
  logic [DW-1:0] da_r;
  logic [DW-1:0] db_r;

  logic          found_s;
  logic [IW-1:0] grant_s;
  logic [W-1:0]  sel_lim_s;
  logic [DW-1:0] sel_da_s;
  logic [DW-1:0] sel_db_s;
  logic          xfer_s;
  logic          core_done_s;
  logic [W-1:0]  core_sum_s;

  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign grant_id  = grant_id_r;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int idx;
    found_s = 1'b0;
    grant_s = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(ptr_r) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        grant_s = IW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Job mux and the combinational accept handshake, only offered in IDLE.
  always_comb begin
    sel_lim_s = req_limit[int'(grant_s)*W  +: W];
    sel_da_s  = req_div_a[int'(grant_s)*DW +: DW];
    sel_db_s  = req_div_b[int'(grant_s)*DW +: DW];
    if ((state_r == S_IDLE) && found_s) begin
      xfer_s    = 1'b1;
      req_ready = ONE_HOT0 << grant_s;
    end else begin
      xfer_s    = 1'b0;
      req_ready = '0;
    end
  end

  // Scheduler FSM: accept a job, run the core, hold the response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      ptr_r        <= IW'(NREQ - 1);
      grant_id_r   <= '0;
      rsp_valid_r  <= '0;
      rsp_sum_r    <= '0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      core_start_r <= 1'b0;
      lim_r        <= '0;
      da_r         <= '0;
      db_r         <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          core_start_r <= 1'b0;
          if (xfer_s) begin
            lim_r      <= sel_lim_s;
            da_r       <= sel_da_s;
            db_r       <= sel_db_s;
            grant_id_r <= grant_s;
            busy_r     <= 1'b1;
            if ((sel_da_s == '0) || (sel_db_s == '0)) begin
              // Rejected job: answer immediately, core stays idle.
              state_r     <= S_RESP;
              rsp_valid_r <= ONE_HOT0 << grant_s;
              rsp_err_r   <= 1'b1;
              rsp_sum_r   <= '0;
            end else begin
              state_r      <= S_RUN;
              core_start_r <= 1'b1;
              rsp_err_r    <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          core_start_r <= 1'b0;
          if (core_done_s) begin
            rsp_sum_r   <= core_sum_s;
            rsp_valid_r <= ONE_HOT0 << grant_id_r;
            state_r     <= S_RESP;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_RESP: begin
          core_start_r <= 1'b0;
          if (rsp_ready[grant_id_r]) begin
            // Served requester becomes lowest priority next round.
            rsp_valid_r <= '0;
            ptr_r       <= grant_id_r;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          rsp_valid_r  <= '0;
          busy_r       <= 1'b0;
          core_start_r <= 1'b0;
        end
      endcase
    end
  end

  multsum_core #(
    .W  (W),
    .DW (DW)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start_r),
    .limit (lim_r),
    .div_a (da_r),
    .div_b (db_r),
    .done  (core_done_s),
    .sum   (core_sum_s)
  );

endmodule

// File: tb/tb_multsum_sched.sv
// Self-checking bench for multsum_sched: directed scenarios plus randomized
// contention checked against a plain arithmetic / round-robin reference model.
module tb_multsum_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_limit;
  logic [NREQ*DW-1:0] req_div_a;
  logic [NREQ*DW-1:0] req_div_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_err;
  logic              busy;
  logic [1:0]        grant_id;

  int total = 0;
  int bad   = 0;
  int ptr_m;
  int cs_cnt = 0;
  int jl[NREQ];
  int ja[NREQ];
  int jb[NREQ];

  multsum_sched #(.NREQ(NREQ), .W(W), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_limit (req_limit),
    .req_div_a (req_div_a),
    .req_div_b (req_div_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // Count core start pulses seen in the middle of each cycle.
  always @(negedge clk) begin
    if (dut.core_start_r) cs_cnt = cs_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum(input int lim, input int a, input int b);
    logic [31:0] s;
    s = 32'd0;
    if (a == 0 || b == 0) return 32'd0;
    for (int k = 0; k < lim; k++) begin
      if ((k % a) == 0 || (k % b) == 0) s = s + 32'(k);
    end
    return s;
  endfunction

  task automatic set_job(input int i, input int lim, input int a, input int b);
    jl[i] = lim; ja[i] = a; jb[i] = b;
    req_limit[i*W +: W]   = 32'(lim);
    req_div_a[i*DW +: DW] = 8'(a);
    req_div_b[i*DW +: DW] = 8'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'd0;
    rsp_ready = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = NREQ - 1;
  endtask

  // Called at a negedge with the DUT in IDLE and req_valid already set.
  task automatic serve_one(input int hold, output int gout);
    int g, cnt, exp_lat;
    logic [31:0] es;
    logic ee, ok;
    #1;
    g = -1;
    for (int off = 1; off <= NREQ; off++) begin
      int i;
      i = (ptr_m + off) % NREQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    gout = g;
    if (g < 0) return;
    chk("req_ready", req_ready, 64'(1 << g));
    es = ref_sum(jl[g], ja[g], jb[g]);
    ee = (ja[g] == 0 || jb[g] == 0);
    exp_lat = ee ? 1 : jl[g] + 3;
    @(negedge clk);
    req_valid[g] = 1'b0;
    cnt = 1;
    ok = 1'b1;
    while (rsp_valid == 4'd0 && cnt < jl[g] + 10) begin
      if (req_ready != 4'd0 || busy != 1'b1) ok = 1'b0;
      @(negedge clk);
      cnt++;
    end
    chk("latency", 64'(cnt), 64'(exp_lat));
    chk("rsp_valid", rsp_valid, 64'(1 << g));
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_err", rsp_err, ee);
    chk("grant_id", grant_id, 64'(g));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 4'($urandom_range(0, 15)) & ~4'(1 << g);
      @(negedge clk);
      if (rsp_sum !== es || rsp_err !== ee || rsp_valid !== 4'(1 << g) ||
          req_ready !== 4'd0 || grant_id !== 2'(g) || busy !== 1'b1) ok = 1'b0;
    end
    chk("busy_hold_stable", ok, 1'b1);
    rsp_ready = 4'(1 << g);
    @(negedge clk);
    rsp_ready = 4'd0;
    ptr_m = g;
    chk("rsp_drop", {rsp_valid, busy}, 64'd0);
  endtask

  initial begin
    int g, c0;
    rst = 1'b1;
    req_valid = 4'd0;
    rsp_ready = 4'd0;
    req_limit = '0;
    req_div_a = '0;
    req_div_b = '0;
    for (int i = 0; i < NREQ; i++) set_job(i, 0, 1, 1);
    do_reset();
    #1;
    chk("rst_outs", {rsp_valid, rsp_sum, rsp_err, busy, grant_id, req_ready}, 64'd0);

    // 1: single job on req0
    @(negedge clk);
    set_job(0, 10, 3, 5);
    req_valid = 4'b0001;
    c0 = cs_cnt;
    serve_one(0, g);
    chk("t1_grant", g, 0);
    chk("t1_one_start", cs_cnt - c0, 1);

    // 2: long job on req2
    set_job(2, 1000, 3, 5);
    req_valid = 4'b0100;
    serve_one(1, g);
    chk("t2_grant", g, 2);

    // 3 + 5: all four contend after reset, first response held 5 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) set_job(i, 10, 3, 5);
    req_valid = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      serve_one(n == 0 ? 5 : 0, g);
      chk("t3_order", g, n);
    end
    req_valid = 4'b1010;
    serve_one(0, g);
    chk("t3_second_a", g, 1);
    serve_one(0, g);
    chk("t3_second_b", g, 3);

    // 4: rejected job
    set_job(1, 10, 0, 5);
    req_valid = 4'b0010;
    c0 = cs_cnt;
    serve_one(2, g);
    chk("t4_grant", g, 1);
    chk("t4_no_start", cs_cnt - c0, 0);

    // 6: reset in the middle of a long run
    set_job(2, 1000, 3, 5);
    req_valid = 4'b0100;
    #1;
    chk("t6_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'd0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = NREQ - 1;
    chk("t6_after_rst", {busy, rsp_valid, grant_id}, 64'd0);
    for (int i = 0; i < NREQ; i++) set_job(i, 6, 2, 3);
    req_valid = 4'b1111;
    serve_one(0, g);
    chk("t6_winner", g, 0);
    req_valid = 4'd0;
    @(negedge clk);

    // Randomized contention against the reference model
    for (int r = 0; r < 80; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_job(i, int'($urandom_range(0, 40)), int'($urandom_range(0, 9)),
                  int'($urandom_range(1, 9)));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if (req_valid == 4'd0) begin
        int i;
        i = int'($urandom_range(0, 3));
        set_job(i, int'($urandom_range(0, 40)), int'($urandom_range(1, 9)), 0);
        req_valid[i] = 1'b1;
      end
      serve_one(int'($urandom_range(0, 3)), g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
